// File: rtl/bp_pkg.sv
// Shared types for the branch predictor: 2-bit saturating counter, its named
// states, the reset value, and the in-flight FIFO entry.
package bp_pkg;

    typedef logic [1:0] ctr_t;

    localparam ctr_t CTR_SNT   = 2'd0;
    localparam ctr_t CTR_WNT   = 2'd1;
    localparam ctr_t CTR_WT    = 2'd2;
    localparam ctr_t CTR_ST    = 2'd3;
    localparam ctr_t CTR_RESET = CTR_WNT;

    // Widest history a FIFO entry can carry; narrower histories are zero-extended.
    localparam int HIST_W = 16;

    typedef struct packed {
        logic [HIST_W-1:0] hist;
        logic              pred;
    } fifo_entry_t;

    function automatic ctr_t ctr_update(ctr_t c, logic taken);
        if (taken) begin
            return (c == CTR_ST) ? CTR_ST : ctr_t'(c + 2'd1);
        end
        return (c == CTR_SNT) ? CTR_SNT : ctr_t'(c - 2'd1);
    endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch/decode-facing handshake of the branch predictor.
// master = fetch/decode side, slave = predictor.
interface branch_predictor_if #(
    parameter int FIFO_DEPTH = 4
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic             lookup_valid;
    logic             lookup_ready;
    logic             pred_taken;
    logic             resolve_valid;
    logic             resolve_taken;
    logic             mispredict;
    logic [CNT_W-1:0] pend_count;

    modport master (
        output lookup_valid, resolve_valid, resolve_taken,
        input  lookup_ready, pred_taken, mispredict, pend_count
    );

    modport slave (
        input  lookup_valid, resolve_valid, resolve_taken,
        output lookup_ready, pred_taken, mispredict, pend_count
    );

endinterface

// File: rtl/pred_fifo.sv
// Synchronous FIFO of unresolved predictions with push, pop and a whole-queue
// flush; flush wins over any same-cycle push or pop.
module pred_fifo
    import bp_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    input  fifo_entry_t            wdata_i,
    output fifo_entry_t            rdata_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    fifo_entry_t      mem_q [DEPTH];

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (flush_i) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (push_i) wr_d = wr_q + PTR_W'(1);
            if (pop_i)  rd_d = rd_q + PTR_W'(1);
            case ({push_i, pop_i})
                2'b10:   cnt_d = cnt_q + CNT_W'(1);
                2'b01:   cnt_d = cnt_q - CNT_W'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i && !flush_i) mem_q[wr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_q];
    assign count_o = cnt_q;

endmodule

// File: rtl/branch_predictor.sv
// Global-history branch predictor: BHR-indexed table of 2-bit counters with
// speculative history and an in-flight FIFO. Optional macro BP_FWD_EN.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int HIST_BITS  = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clock,
    input  logic              reset,
    branch_predictor_if.slave bus
);
    localparam int TBL   = 2 ** HIST_BITS;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    ctr_t                 bpt_q [TBL];
    logic [HIST_BITS-1:0] bhr_q, bhr_d;

    fifo_entry_t          head, push_entry;
    logic [CNT_W-1:0]     count;
    logic [HIST_BITS-1:0] h;
    ctr_t                 upd_ctr, pred_ctr;
    logic                 resolve, accept;

    assign h       = head.hist[HIST_BITS-1:0];
    assign resolve = bus.resolve_valid && (count != '0);
    assign upd_ctr = ctr_update(bpt_q[h], bus.resolve_taken);

`ifdef BP_FWD_EN
    assign pred_ctr = (resolve && (h == bhr_q)) ? upd_ctr : bpt_q[bhr_q];
`else
    assign pred_ctr = bpt_q[bhr_q];
`endif

    assign bus.pred_taken   = pred_ctr[1];
    assign bus.mispredict   = resolve && (bus.resolve_taken != head.pred);
    assign bus.lookup_ready = (count != CNT_W'(FIFO_DEPTH)) && !bus.mispredict;
    assign bus.pend_count   = count;
    assign accept           = bus.lookup_valid && bus.lookup_ready;
    assign push_entry       = '{hist: HIST_W'(bhr_q), pred: bus.pred_taken};

    if (HIST_BITS < HIST_W) begin : g_hist_pad
        logic unused_hist_pad;
        assign unused_hist_pad = ^head.hist[HIST_W-1:HIST_BITS];
    end

    // A mispredict rebuilds history from the resolved branch, discarding speculation.
    always_comb begin
        bhr_d = bhr_q;
        if (bus.mispredict) begin
            bhr_d = {h[HIST_BITS-2:0], bus.resolve_taken};
        end else if (accept) begin
            bhr_d = {bhr_q[HIST_BITS-2:0], bus.pred_taken};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            bhr_q <= '0;
            for (int i = 0; i < TBL; i++) bpt_q[i] <= CTR_RESET;
        end else begin
            bhr_q <= bhr_d;
            if (resolve) bpt_q[h] <= upd_ctr;
        end
    end

    pred_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clock),
        .rst_i   (reset),
        .push_i  (accept),
        .pop_i   (resolve),
        .flush_i (bus.mispredict),
        .wdata_i (push_entry),
        .rdata_o (head),
        .count_o (count)
    );

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios plus random
// traffic against a queue-based reference model. Honours BP_FWD_EN.
module tb_branch_predictor;

    localparam int  HB    = 4;
    localparam int  DEPTH = 4;
    localparam int  MASK  = (1 << HB) - 1;
`ifdef BP_FWD_EN
    localparam bit  FWD   = 1'b1;
`else
    localparam bit  FWD   = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    branch_predictor_if #(.FIFO_DEPTH(DEPTH)) bus ();

    branch_predictor #(
        .HIST_BITS  (HB),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    // Reference model state
    int m_bpt [1 << HB];
    int m_bhr;
    int m_h [$];
    bit m_p [$];

    // {pred_taken, lookup_ready, mispredict, pend_count[2:0]}
    logic [5:0] o_v, e_v;

    task automatic model_reset();
        for (int i = 0; i < (1 << HB); i++) m_bpt[i] = 1;
        m_bhr = 0;
        m_h.delete();
        m_p.delete();
    endtask

    task automatic model_step(input logic lv, input logic rv, input logic rt);
        int  cnt, h, nc, pc;
        bit  p, res, misp, pred, rdy, acc;
        cnt  = m_h.size();
        res  = rv && (cnt != 0);
        h    = res ? m_h[0] : 0;
        p    = res ? m_p[0] : 1'b0;
        nc   = 0;
        if (res) begin
            if (rt) nc = (m_bpt[h] == 3) ? 3 : m_bpt[h] + 1;
            else    nc = (m_bpt[h] == 0) ? 0 : m_bpt[h] - 1;
        end
        pc   = (FWD && res && (h == m_bhr)) ? nc : m_bpt[m_bhr];
        pred = (pc >= 2);
        misp = res && (rt != p);
        rdy  = (cnt != DEPTH) && !misp;
        acc  = lv && rdy;
        e_v  = {pred, rdy, misp, 3'(cnt)};
        if (res) m_bpt[h] = nc;
        if (misp) begin
            m_h.delete();
            m_p.delete();
            m_bhr = ((h << 1) | int'(rt)) & MASK;
        end else begin
            if (res) begin
                void'(m_h.pop_front());
                void'(m_p.pop_front());
            end
            if (acc) begin
                m_h.push_back(m_bhr);
                m_p.push_back(pred);
                m_bhr = ((m_bhr << 1) | int'(pred)) & MASK;
            end
        end
    endtask

    // One clock: drive on the falling edge, sample 1 ns later, advance the model.
    task automatic cyc(input logic lv, input logic rv, input logic rt);
        @(negedge clock);
        bus.lookup_valid  = lv;
        bus.resolve_valid = rv;
        bus.resolve_taken = rt;
        #1;
        o_v = {bus.pred_taken, bus.lookup_ready, bus.mispredict, bus.pend_count};
        model_step(lv, rv, rt);
        @(posedge clock);
    endtask

    task automatic do_reset(input logic lv, input logic rv);
        @(negedge clock);
        reset             = 1'b1;
        bus.lookup_valid  = lv;
        bus.resolve_valid = rv;
        bus.resolve_taken = 1'b1;
        @(posedge clock);
        @(negedge clock);
        reset             = 1'b0;
        bus.lookup_valid  = 1'b0;
        bus.resolve_valid = 1'b0;
        bus.resolve_taken = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset(1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        checks++;
        if (o_v[5] !== 1'b0) begin
            errors++; $display("FAIL reset_pred_taken got=%b required=0", o_v[5]);
        end
        checks++;
        if (o_v[4] !== 1'b1) begin
            errors++; $display("FAIL reset_lookup_ready got=%b required=1", o_v[4]);
        end
        checks++;
        if (o_v[3] !== 1'b0) begin
            errors++; $display("FAIL reset_mispredict got=%b required=0", o_v[3]);
        end
        checks++;
        if (o_v[2:0] !== 3'd0) begin
            errors++; $display("FAIL reset_pend_count got=%0d required=0", o_v[2:0]);
        end
    endtask

    task automatic test_single_lookup();
        do_reset(1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        checks++;
        if (o_v[5] !== 1'b0) begin
            errors++; $display("FAIL single_pred got=%b required=0", o_v[5]);
        end
        cyc(1'b0, 1'b0, 1'b0);
        checks++;
        if (o_v[2:0] !== 3'd1) begin
            errors++; $display("FAIL single_pend got=%0d required=1", o_v[2:0]);
        end
        checks++;
        if (dut.bhr_q !== 4'b0000) begin
            errors++; $display("FAIL single_bhr got=%b required=0000", dut.bhr_q);
        end
    endtask

    task automatic test_mispredict_flush();
        do_reset(1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1);
        checks++;
        if (o_v[3] !== 1'b1) begin
            errors++; $display("FAIL flush_first_mispredict got=%b required=1", o_v[3]);
        end
        cyc(1'b0, 1'b1, 1'b1);
        checks++;
        if (o_v[3] !== 1'b0 || o_v[2:0] !== 3'd0) begin
            errors++;
            $display("FAIL flush_second_resolve got misp=%b pend=%0d required misp=0 pend=0", o_v[3], o_v[2:0]);
        end
        cyc(1'b0, 1'b0, 1'b0);
        checks++;
        if (dut.bhr_q !== 4'b0001) begin
            errors++; $display("FAIL flush_bhr got=%b required=0001", dut.bhr_q);
        end
        checks++;
        if (dut.bpt_q[0] !== 2'd2) begin
            errors++; $display("FAIL flush_bpt0 got=%0d required=2", dut.bpt_q[0]);
        end
    endtask

    task automatic test_full();
        do_reset(1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 1'b0, 1'b0);
            checks++;
            if (o_v !== e_v) begin
                errors++; $display("FAIL full_step%0d got=%b required=%b", i, o_v, e_v);
            end
        end
        cyc(1'b0, 1'b0, 1'b0);
        checks++;
        if (o_v[2:0] !== 3'd4 || o_v[4] !== 1'b0) begin
            errors++;
            $display("FAIL full_final got pend=%0d ready=%b required pend=4 ready=0", o_v[2:0], o_v[4]);
        end
    endtask

    task automatic test_saturation();
        do_reset(1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        checks++;
        if (dut.bpt_q[0] !== 2'd0) begin
            errors++; $display("FAIL sat_low got=%0d required=0", dut.bpt_q[0]);
        end
        do_reset(1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1);
        for (int k = 0; k < 2; k++) begin
            for (int j = 0; j < 10; j++) begin
                if (j < 4)      cyc(1'b1, 1'b0, 1'b0);
                else if (j < 8) cyc(1'b0, 1'b1, 1'b0);
                else if (j == 8) cyc(1'b1, 1'b0, 1'b0);
                else            cyc(1'b0, 1'b1, 1'b1);
                checks++;
                if (o_v !== e_v) begin
                    errors++; $display("FAIL sat_seq%0d_%0d got=%b required=%b", k, j, o_v, e_v);
                end
            end
        end
        cyc(1'b0, 1'b0, 1'b0);
        checks++;
        if (dut.bpt_q[0] !== 2'd3) begin
            errors++; $display("FAIL sat_high got=%0d required=3", dut.bpt_q[0]);
        end
        checks++;
        if (dut.bpt_q[1] !== 2'd0) begin
            errors++; $display("FAIL sat_low_hold got=%0d required=0", dut.bpt_q[1]);
        end
    endtask

    task automatic test_forward();
        do_reset(1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1);
        checks++;
        if (o_v[5] !== FWD) begin
            errors++; $display("FAIL forward_pred got=%b required=%b", o_v[5], FWD);
        end
        checks++;
        if (o_v !== e_v) begin
            errors++; $display("FAIL forward_model got=%b required=%b", o_v, e_v);
        end
    endtask

    task automatic test_reset_midop();
        do_reset(1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1);
        cyc(1'b1, 1'b0, 1'b0);
        do_reset(1'b1, 1'b1);
        cyc(1'b0, 1'b0, 1'b0);
        checks++;
        if (o_v !== 6'b010000) begin
            errors++; $display("FAIL midop_reset_outputs got=%b required=010000", o_v);
        end
        checks++;
        if (dut.bpt_q[0] !== 2'd1 || dut.bhr_q !== 4'b0000) begin
            errors++;
            $display("FAIL midop_reset_state got bpt0=%0d bhr=%b required bpt0=1 bhr=0000", dut.bpt_q[0], dut.bhr_q);
        end
    endtask

    task automatic test_random();
        logic lv, rv, rt;
        do_reset(1'b0, 1'b0);
        for (int n = 0; n < 600; n++) begin
            if (n % 150 == 149) begin
                do_reset(1'($urandom), 1'($urandom));
            end
            lv = ($urandom % 4) != 0;
            rv = ($urandom % 3) == 0;
            if (m_h.size() != 0) rt = (($urandom % 6) == 0) ? !m_p[0] : m_p[0];
            else                 rt = 1'($urandom);
            cyc(lv, rv, rt);
            checks++;
            if (o_v !== e_v) begin
                errors++; $display("FAIL random_cyc%0d got=%b required=%b", n, o_v, e_v);
            end
        end
        cyc(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < (1 << HB); i++) begin
            checks++;
            if (int'(dut.bpt_q[i]) != m_bpt[i]) begin
                errors++; $display("FAIL random_bpt%0d got=%0d required=%0d", i, dut.bpt_q[i], m_bpt[i]);
            end
        end
        checks++;
        if (int'(dut.bhr_q) != m_bhr) begin
            errors++; $display("FAIL random_bhr got=%0d required=%0d", dut.bhr_q, m_bhr);
        end
    endtask

    // Runs from whatever table state the random phase left, so stored predictions vary.
    task automatic test_back_to_back();
        int guard;
        guard = 0;
        while (m_h.size() < DEPTH && guard < 8) begin
            cyc(1'b1, 1'b0, 1'b0);
            guard++;
        end
        checks++;
        if (m_h.size() != DEPTH) begin
            errors++; $display("FAIL b2b_fill_timeout got=%0d required=%0d", m_h.size(), DEPTH);
        end
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 1'b1, m_p[0]);
            checks++;
            if (o_v !== e_v) begin
                errors++; $display("FAIL b2b_cyc%0d got=%b required=%b", i, o_v, e_v);
            end
        end
    endtask

    initial begin
        bus.lookup_valid  = 1'b0;
        bus.resolve_valid = 1'b0;
        bus.resolve_taken = 1'b0;
        model_reset();
        test_reset();
        test_single_lookup();
        test_mispredict_flush();
        test_full();
        test_saturation();
        test_forward();
        test_reset_midop();
        test_random();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
